regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single register-file write port and shares it between two writers.
  - The in-order pipeline writeback stage (RegWrite/Rd/Result of W stage).
  - A long-latency execution unit (divider/multi-cycle ops) that returns results out of band.
- Pipeline writes always win.
- Long-unit results are buffered in a small FIFO and drained in free slots.
- A starvation counter forces a pipeline stall slot when needed.
- A busy-register scoreboard is exported for issue-side hazard checks.

Parameters:
- FIFO_DEPTH, 2, number of buffered long-unit results (power of two, >=2)
- STARVE_LIMIT, 4, consecutive cycles with a non-empty FIFO and no drain before PipeStall is raised

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- RegWriteW  input  1  pipeline writeback enable
- RdW  input  5  pipeline destination register
- ResultW  input  32  pipeline writeback data
- LongValid  input  1  long unit has a result
- LongRd  input  5  long-unit destination register
- LongData  input  32  long-unit result data
- LongReady  output  1  arbiter accepts long result this cycle
- IssueLong  input  1  a long op is issued this cycle
- IssueRd  input  5  destination of the issued long op
- RegWrite_rf  output  1  registered regfile write enable
- Rd_rf  output  5  registered regfile write address
- WD_rf  output  32  registered regfile write data
- PipeStall  output  1  registered request for the pipeline to insert a writeback bubble
- BusyMask  output  32  scoreboard; bit n=1 means x(n) has a long result outstanding

Behaviour:
- Clock and reset
  - Single clock domain (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
  - Reset clears: RegWrite_rf=0, Rd_rf=0, WD_rf=0, PipeStall=0, BusyMask=0, FIFO empty, starve counter=0.
  - LongReady=0 while rst=1.
- Slot definitions
  - Pipe write valid: pw = RegWriteW && RdW!=0.
  - Free slot: !pw.
- Write-port selection each cycle; the selected write appears on *_rf the next cycle (1-cycle latency).
  1. pw: write RdW/ResultW.
  2. Else if FIFO non-empty: pop head and write it.
  3. Else if LongValid: bypass, write LongRd/LongData directly with no enqueue; LongReady=1.
  4. Else RegWrite_rf=0 next cycle. Rd_rf/WD_rf hold their last value.
- Enqueue
  - LongReady = !full (and !rst); no same-cycle pass-through when full.
  - Long result accepted when LongValid && LongReady, and not taken by the bypass path.
  - Enqueue and pop in the same cycle are allowed; count is unchanged.
- Rd=0 handling
  - A long result with LongRd=0 is accepted and popped like any other entry.
  - It produces RegWrite_rf=0 and consumes no write slot, so the next entry may drain on the following cycle.
  - A pipeline write with RdW=0 is never a write; the slot is treated as free.
- Starvation
  - Counter increments each cycle in which the FIFO is non-empty and pw=1.
  - Counter clears on any pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, PipeStall=1 next cycle for exactly one cycle, and the counter clears.
  - The pipeline must present RegWriteW=0 in the cycle PipeStall is high.
  - If it does not, the pipe write still wins (no data loss) and counting resumes from 0.
- Scoreboard
  - IssueLong && IssueRd!=0 sets BusyMask[IssueRd].
  - A long-result write to rd clears its bit. The clear takes effect in the same edge RegWrite_rf rises for that entry.
  - Simultaneous set and clear of the same bit: set wins.
  - A pipe write to a busy rd leaves the bit unchanged; WAW ordering is the issue logic's responsibility.
  - BusyMask[0] is always 0.
- Reset mid-operation
  - FIFO contents are discarded.
  - No write is emitted on the edge where rst=1.

Optional Feature:
- Macro: WB_CONFLICT_CNT_EN.
- When defined, adds output ConflictCount [31:0].
  - Increments by 1 on each cycle where pw=1 and (FIFO non-empty or LongValid).
  - Saturates at 32'hFFFFFFFF; reset to 0.
- When not defined: no port, no counter logic, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=1 two cycles with RegWriteW=1 and LongValid=1.
  - Expected: RegWrite_rf=0, BusyMask=0, LongReady=0 throughout.
  - First cycle after release: LongReady=1.
- Bypass: FIFO empty, RegWriteW=0, LongValid=1, LongRd=5, LongData=32'hDEADBEEF, with BusyMask[5]=1 from a prior IssueLong.
  - Expected next cycle: RegWrite_rf=1, Rd_rf=5, WD_rf=32'hDEADBEEF, BusyMask[5]=0.
- Conflict and drain: pw=1 (RdW=3, ResultW=1) for three cycles while long results rd 7 then rd 8 arrive.
  - Expected: both results queued; LongReady=0 once full.
  - Writes to x3 for three cycles, then x7 and x8 on the next two free cycles, in order.
- Starvation (STARVE_LIMIT=4): FIFO holds one entry, pw=1 continuously.
  - Expected: PipeStall=1 for one cycle after the 4th blocked cycle.
  - Bench drops RegWriteW in that cycle; the head is written the following cycle.
- Rd=0 and scoreboard race: a long result with LongRd=0 queued ahead of rd 9; IssueLong with IssueRd=9 in the same cycle rd 9 is written.
  - Expected: no write for the rd0 entry; x9 written; BusyMask[9] remains 1.
- Mid-operation reset: FIFO holding 2 entries, assert rst one cycle.
  - Expected: no writes afterward and the FIFO is empty.
  - With WB_CONFLICT_CNT_EN defined: ConflictCount=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the single register-file write port.
// Pipeline writeback always wins the port. Long-latency unit results are
// written directly when the slot is free and the FIFO is empty, and are
// otherwise buffered and drained in free slots. A starvation counter requests
// a pipeline writeback bubble. A busy-register scoreboard is exported.
// Optional feature macro: WB_CONFLICT_CNT_EN (adds ConflictCount output).
module regfile_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic        LongValid,
    input  logic [4:0]  LongRd,
    input  logic [31:0] LongData,
    output logic        LongReady,
    input  logic        IssueLong,
    input  logic [4:0]  IssueRd,
    output logic        RegWrite_rf,
    output logic [4:0]  Rd_rf,
    output logic [31:0] WD_rf,
    output logic        PipeStall,
    output logic [31:0] BusyMask
`ifdef WB_CONFLICT_CNT_EN
    ,
    output logic [31:0] ConflictCount
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

    // FIFO storage and pointers
    logic [4:0]       fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    // Registered write port, stall request, scoreboard, starvation counter
    logic             we_q, we_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      wd_q, wd_d;
    logic             stall_q, stall_d;
    logic [31:0]      busy_q, busy_d;
    logic [STV_W-1:0] stv_q, stv_d;

    // Per-cycle decisions
    logic        pw;
    logic        fifo_empty, fifo_full;
    logic        sel_pop, sel_byp;
    logic        do_push;
    logic [4:0]  head_rd;
    logic [31:0] head_data;
    logic        long_clr;
    logic [4:0]  long_clr_rd;

    assign RegWrite_rf = we_q;
    assign Rd_rf       = rd_q;
    assign WD_rf       = wd_q;
    assign PipeStall   = stall_q;
    assign BusyMask    = busy_q;

    // Slot classification and FIFO handshake
    always_comb begin
        pw         = RegWriteW && (RdW != 5'd0);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        LongReady  = !rst && !fifo_full;
        head_rd    = fifo_rd_q[rd_ptr_q];
        head_data  = fifo_data_q[rd_ptr_q];
        sel_pop    = !pw && !fifo_empty;
        sel_byp    = !pw && fifo_empty && LongValid;
        do_push    = LongValid && LongReady && !sel_byp;
        count_d    = count_q;
        case ({do_push, sel_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Write-port selection; Rd=0 long results are consumed without a write
    always_comb begin
        we_d        = 1'b0;
        rd_d        = rd_q;
        wd_d        = wd_q;
        long_clr    = 1'b0;
        long_clr_rd = 5'd0;
        if (pw) begin
            we_d = 1'b1;
            rd_d = RdW;
            wd_d = ResultW;
        end else if (sel_pop) begin
            if (head_rd != 5'd0) begin
                we_d        = 1'b1;
                rd_d        = head_rd;
                wd_d        = head_data;
                long_clr    = 1'b1;
                long_clr_rd = head_rd;
            end
        end else if (sel_byp) begin
            if (LongRd != 5'd0) begin
                we_d        = 1'b1;
                rd_d        = LongRd;
                wd_d        = LongData;
                long_clr    = 1'b1;
                long_clr_rd = LongRd;
            end
        end
    end

    // Scoreboard update: clear on long-result write, then set on issue (set wins)
    always_comb begin
        busy_d = busy_q;
        if (long_clr) begin
            busy_d[long_clr_rd] = 1'b0;
        end
        if (IssueLong && (IssueRd != 5'd0)) begin
            busy_d[IssueRd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Starvation counter; the limit-reaching increment folds straight into a stall
    always_comb begin
        stall_d = 1'b0;
        stv_d   = stv_q;
        if (fifo_empty || sel_pop) begin
            stv_d = '0;
        end else if (pw) begin
            if ((stv_q + 1'b1) == LIMIT_C) begin
                stall_d = 1'b1;
                stv_d   = '0;
            end else begin
                stv_d = stv_q + 1'b1;
            end
        end
    end

    // FIFO storage write (contents need no reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_rd_q[wr_ptr_q]   <= LongRd;
            fifo_data_q[wr_ptr_q] <= LongData;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            rd_q     <= '0;
            wd_q     <= '0;
            stall_q  <= 1'b0;
            busy_q   <= '0;
            stv_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (sel_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            wd_q    <= wd_d;
            stall_q <= stall_d;
            busy_q  <= busy_d;
            stv_q   <= stv_d;
        end
    end

`ifdef WB_CONFLICT_CNT_EN
    logic [31:0] conflict_q;
    logic        conflict;

    assign ConflictCount = conflict_q;
    assign conflict      = pw && (!fifo_empty || LongValid);

    // Saturating count of cycles where a long result contended with a pipe write
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
        end else if (conflict && (conflict_q != '1)) begin
            conflict_q <= conflict_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a scoreboard queue of expected
// register-file writes, filled when stimulus is driven and drained by a
// monitor, plus per-scenario checks of stall, ready and scoreboard outputs.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        LongValid;
    logic [4:0]  LongRd;
    logic [31:0] LongData;
    logic        LongReady;
    logic        IssueLong;
    logic [4:0]  IssueRd;
    logic        RegWrite_rf;
    logic [4:0]  Rd_rf;
    logic [31:0] WD_rf;
    logic        PipeStall;
    logic [31:0] BusyMask;
`ifdef WB_CONFLICT_CNT_EN
    logic [31:0] ConflictCount;
`endif

    int  passed = 0;
    int  total  = 0;
    wb_t exp_q[$];
    wb_t mon_e;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .LongValid(LongValid), .LongRd(LongRd), .LongData(LongData),
        .LongReady(LongReady),
        .IssueLong(IssueLong), .IssueRd(IssueRd),
        .RegWrite_rf(RegWrite_rf), .Rd_rf(Rd_rf), .WD_rf(WD_rf),
        .PipeStall(PipeStall), .BusyMask(BusyMask)
`ifdef WB_CONFLICT_CNT_EN
        , .ConflictCount(ConflictCount)
`endif
    );

    // Monitor: every emitted write must match the head of the expected queue
    always @(negedge clk) begin
        if (RegWrite_rf === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write", Rd_rf, WD_rf);
            end else begin
                mon_e = exp_q.pop_front();
                if (Rd_rf !== mon_e.rd || WD_rf !== mon_e.data)
                    $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                             Rd_rf, WD_rf, mon_e.rd, mon_e.data);
                else
                    passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'd0;
        LongValid = 1'b0; LongRd = 5'd0; LongData = 32'd0;
        IssueLong = 1'b0; IssueRd = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'h1234;
        LongValid = 1'b1; LongRd = 5'd6; LongData = 32'h5678;
        IssueLong = 1'b1; IssueRd = 5'd7;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (RegWrite_rf !== 1'b0) $display("FAIL reset_we: got %b, required 0", RegWrite_rf);
            else passed++;
            total++;
            if (BusyMask !== 32'd0) $display("FAIL reset_busy: got %h, required 0", BusyMask);
            else passed++;
            total++;
            if (LongReady !== 1'b0) $display("FAIL reset_ready: got %b, required 0", LongReady);
            else passed++;
        end
        total++;
        if (Rd_rf !== 5'd0 || WD_rf !== 32'd0 || PipeStall !== 1'b0)
            $display("FAIL reset_regs: got rd=%0d wd=%h stall=%b, required 0/0/0", Rd_rf, WD_rf, PipeStall);
        else passed++;
        rst = 1'b0;
        idle_inputs();
        #1;
        total++;
        if (LongReady !== 1'b1) $display("FAIL release_ready: got %b, required 1", LongReady);
        else passed++;
        tick();
    endtask

    task automatic test_bypass();
        IssueLong = 1'b1; IssueRd = 5'd5;
        tick();
        IssueLong = 1'b0; IssueRd = 5'd0;
        total++;
        if (BusyMask !== 32'h0000_0020) $display("FAIL bypass_issue: got %h, required 00000020", BusyMask);
        else passed++;
        LongValid = 1'b1; LongRd = 5'd5; LongData = 32'hDEADBEEF;
        total++;
        if (LongReady !== 1'b1) $display("FAIL bypass_ready: got %b, required 1", LongReady);
        else passed++;
        exp_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
        tick();
        idle_inputs();
        total++;
        if (RegWrite_rf !== 1'b1 || Rd_rf !== 5'd5 || WD_rf !== 32'hDEADBEEF)
            $display("FAIL bypass_write: got we=%b rd=%0d wd=%h, required 1/5/deadbeef", RegWrite_rf, Rd_rf, WD_rf);
        else passed++;
        total++;
        if (BusyMask !== 32'd0) $display("FAIL bypass_clear: got %h, required 0", BusyMask);
        else passed++;
        tick();
        total++;
        if (RegWrite_rf !== 1'b0) $display("FAIL bypass_idle: got %b, required 0", RegWrite_rf);
        else passed++;
    endtask

    task automatic test_conflict_drain();
        IssueLong = 1'b1; IssueRd = 5'd7;
        tick();
        IssueRd = 5'd8;
        tick();
        IssueLong = 1'b0; IssueRd = 5'd0;
        total++;
        if (BusyMask !== 32'h0000_0180) $display("FAIL conflict_issue: got %h, required 00000180", BusyMask);
        else passed++;
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'd1;
        for (int i = 0; i < 3; i++) begin
            LongValid = 1'b1;
            LongRd    = (i == 0) ? 5'd7 : (i == 1) ? 5'd8 : 5'd10;
            LongData  = (i == 0) ? 32'h70 : (i == 1) ? 32'h80 : 32'hA0;
            total++;
            if (LongReady !== ((i < 2) ? 1'b1 : 1'b0))
                $display("FAIL conflict_ready%0d: got %b, required %b", i, LongReady, (i < 2));
            else passed++;
            exp_q.push_back('{rd: 5'd3, data: 32'd1});
            tick();
            total++;
            if (RegWrite_rf !== 1'b1 || Rd_rf !== 5'd3)
                $display("FAIL conflict_pipe%0d: got we=%b rd=%0d, required 1/3", i, RegWrite_rf, Rd_rf);
            else passed++;
        end
        idle_inputs();
`ifdef WB_CONFLICT_CNT_EN
        total++;
        if (ConflictCount !== 32'd3) $display("FAIL conflict_count: got %0d, required 3", ConflictCount);
        else passed++;
`endif
        exp_q.push_back('{rd: 5'd7, data: 32'h70});
        tick();
        total++;
        if (Rd_rf !== 5'd7 || BusyMask !== 32'h0000_0100)
            $display("FAIL drain_first: got rd=%0d busy=%h, required 7/00000100", Rd_rf, BusyMask);
        else passed++;
        exp_q.push_back('{rd: 5'd8, data: 32'h80});
        tick();
        total++;
        if (Rd_rf !== 5'd8 || BusyMask !== 32'd0)
            $display("FAIL drain_second: got rd=%0d busy=%h, required 8/0", Rd_rf, BusyMask);
        else passed++;
        tick();
        total++;
        if (RegWrite_rf !== 1'b0 || LongReady !== 1'b1)
            $display("FAIL drain_done: got we=%b ready=%b, required 0/1", RegWrite_rf, LongReady);
        else passed++;
    endtask

    task automatic test_starvation();
        RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'h100;
        LongValid = 1'b1; LongRd = 5'd11; LongData = 32'hB0B0;
        exp_q.push_back('{rd: 5'd4, data: 32'h100});
        tick();
        LongValid = 1'b0; LongRd = 5'd0; LongData = 32'd0;
        for (int i = 0; i < 4; i++) begin
            ResultW = 32'h101 + i;
            exp_q.push_back('{rd: 5'd4, data: 32'h101 + i});
            tick();
            total++;
            if (PipeStall !== ((i == 3) ? 1'b1 : 1'b0))
                $display("FAIL starve_stall%0d: got %b, required %b", i, PipeStall, (i == 3));
            else passed++;
        end
        idle_inputs();
        exp_q.push_back('{rd: 5'd11, data: 32'hB0B0});
        tick();
        total++;
        if (PipeStall !== 1'b0 || RegWrite_rf !== 1'b1 || Rd_rf !== 5'd11)
            $display("FAIL starve_drain: got stall=%b we=%b rd=%0d, required 0/1/11", PipeStall, RegWrite_rf, Rd_rf);
        else passed++;
        tick();
    endtask

    task automatic test_rd0_race();
        IssueLong = 1'b1; IssueRd = 5'd9;
        tick();
        IssueLong = 1'b0; IssueRd = 5'd0;
        RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h22;
        LongValid = 1'b1; LongRd = 5'd0; LongData = 32'hAAAA;
        exp_q.push_back('{rd: 5'd2, data: 32'h22});
        tick();
        ResultW = 32'h23; LongRd = 5'd9; LongData = 32'h99;
        exp_q.push_back('{rd: 5'd2, data: 32'h23});
        tick();
        idle_inputs();
        tick();
        total++;
        if (RegWrite_rf !== 1'b0) $display("FAIL rd0_nowrite: got %b, required 0", RegWrite_rf);
        else passed++;
        IssueLong = 1'b1; IssueRd = 5'd9;
        exp_q.push_back('{rd: 5'd9, data: 32'h99});
        tick();
        idle_inputs();
        total++;
        if (RegWrite_rf !== 1'b1 || Rd_rf !== 5'd9 || WD_rf !== 32'h99)
            $display("FAIL rd9_write: got we=%b rd=%0d wd=%h, required 1/9/99", RegWrite_rf, Rd_rf, WD_rf);
        else passed++;
        total++;
        if (BusyMask !== 32'h0000_0200) $display("FAIL race_setwins: got %h, required 00000200", BusyMask);
        else passed++;
        tick();
    endtask

    task automatic test_mid_reset();
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'd5;
        LongValid = 1'b1; LongRd = 5'd12; LongData = 32'hC1;
        exp_q.push_back('{rd: 5'd3, data: 32'd5});
        tick();
        LongRd = 5'd13; LongData = 32'hC2;
        exp_q.push_back('{rd: 5'd3, data: 32'd5});
        tick();
        idle_inputs();
        total++;
        if (LongReady !== 1'b0) $display("FAIL midrst_full: got %b, required 0", LongReady);
        else passed++;
        rst = 1'b1;
        tick();
        total++;
        if (RegWrite_rf !== 1'b0 || BusyMask !== 32'd0 || PipeStall !== 1'b0)
            $display("FAIL midrst_regs: got we=%b busy=%h stall=%b, required 0/0/0", RegWrite_rf, BusyMask, PipeStall);
        else passed++;
`ifdef WB_CONFLICT_CNT_EN
        total++;
        if (ConflictCount !== 32'd0) $display("FAIL midrst_conflict: got %0d, required 0", ConflictCount);
        else passed++;
`endif
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (RegWrite_rf !== 1'b0 || LongReady !== 1'b1)
                $display("FAIL midrst_empty%0d: got we=%b ready=%b, required 0/1", i, RegWrite_rf, LongReady);
            else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_bypass();
        test_conflict_drain();
        test_starvation();
        test_rd0_race();
        test_mid_reset();
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) $display("FAIL queue_drained: got %0d pending, required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
